hart_debug_ctrl: RTL



---
 rtl/hart_debug_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/hart_debug_ctrl.sv
// Hart-side debug responder: halt/resume/step handshake with the Debug Module and abstract
// access to dcsr, dpc and the GPRs. Define HART_DBG_STEP_EN to build in single-step support.
module hart_debug_ctrl (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        halt_req_i,
    input  logic        rd_wr_en_i,
    input  logic        rd_wr_i,
    input  logic [15:0] rd_wr_address_i,
    inout  wire  [31:0] rd_wr_data_io,
    output logic        halt_ack_o,
    output logic        resume_ack_o,
    output logic        stepping_o,
    output logic        first_step_exec_o,
    input  logic        core_idle_i,
    input  logic        core_retire_i,
    input  logic [31:0] core_pc_i,
    output logic        core_stall_o,
    output logic        core_pc_set_o,
    output logic [31:0] core_pc_o,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_addr_o,
    output logic [31:0] gpr_wdata_o,
    input  logic [31:0] gpr_rdata_i
);

    typedef enum logic [2:0] {
        RUNNING   = 3'd0,
        HALT_WAIT = 3'd1,
        HALTED    = 3'd2,
        RESUME    = 3'd3
`ifdef HART_DBG_STEP_EN
        ,
        STEP_RUN  = 3'd4,
        STEP_HALT = 3'd5
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] dpc_q, dpc_d;
    logic        ebreakm_q, ebreakm_d;
    logic [2:0]  cause_q, cause_d;
    logic        step_bit;
    logic        en_q;
    logic        halt_ack_q, resume_ack_q, stall_q, pc_set_q;
    logic [31:0] core_pc_q;
    logic        gpr_we_q;
    logic [4:0]  gpr_waddr_q;
    logic [31:0] gpr_wdata_q;

    logic        halted, sel_dcsr, sel_dpc, sel_gpr;
    logic        wr_fire, rd_active, gpr_hit;
    logic [31:0] dcsr_val, rd_data;

`ifdef HART_DBG_STEP_EN
    logic step_q, step_d;
    logic stepping_q, first_step_q;
    assign step_bit          = step_q;
    assign stepping_o        = stepping_q;
    assign first_step_exec_o = first_step_q;
`else
    logic unused_retire;
    assign unused_retire     = core_retire_i;
    assign step_bit          = 1'b0;
    assign stepping_o        = 1'b0;
    assign first_step_exec_o = 1'b0;
`endif

    assign halted    = (state_q == HALTED);
    assign sel_dcsr  = (rd_wr_address_i == 16'h07B0);
    assign sel_dpc   = (rd_wr_address_i == 16'h07B1);
    assign sel_gpr   = (rd_wr_address_i[15:5] == 11'h080);
    // Writes fire once per enable pulse; a held enable does not repeat the write.
    assign wr_fire   = halted & rd_wr_en_i & rd_wr_i & ~en_q;
    assign rd_active = halted & rd_wr_en_i & ~rd_wr_i;
    assign gpr_hit   = wr_fire & sel_gpr & (rd_wr_address_i[4:0] != 5'd0);

    assign dcsr_val = {4'd4, 12'd0, ebreakm_q, 6'd0, cause_q, 3'd0, step_bit, 2'b11};

    always_comb begin
        rd_data = 32'd0;
        if (sel_dcsr)
            rd_data = dcsr_val;
        else if (sel_dpc)
            rd_data = dpc_q;
        else if (sel_gpr)
            rd_data = gpr_rdata_i;
    end

    assign rd_wr_data_io = rd_active ? rd_data : 32'bz;

    // The register file address is shared: a pending write owns it, otherwise a live GPR read.
    assign gpr_addr_o = gpr_we_q ? gpr_waddr_q :
                        (rd_active && sel_gpr) ? rd_wr_address_i[4:0] : 5'd0;

    assign halt_ack_o    = halt_ack_q;
    assign resume_ack_o  = resume_ack_q;
    assign core_stall_o  = stall_q;
    assign core_pc_set_o = pc_set_q;
    assign core_pc_o     = core_pc_q;
    assign gpr_we_o      = gpr_we_q;
    assign gpr_wdata_o   = gpr_wdata_q;

    always_comb begin
        dpc_d     = dpc_q;
        ebreakm_d = ebreakm_q;
        cause_d   = cause_q;
`ifdef HART_DBG_STEP_EN
        step_d    = step_q;
`endif
        if (wr_fire && sel_dpc)
            dpc_d = rd_wr_data_io;
        if (wr_fire && sel_dcsr) begin
            ebreakm_d = rd_wr_data_io[15];
`ifdef HART_DBG_STEP_EN
            step_d    = rd_wr_data_io[2];
`endif
        end
        if (state_q == HALT_WAIT && core_idle_i) begin
            dpc_d   = core_pc_i;
            cause_d = 3'd3;
        end
`ifdef HART_DBG_STEP_EN
        if (state_q == STEP_HALT && core_idle_i) begin
            dpc_d   = core_pc_i;
            cause_d = 3'd4;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= RUNNING;
            dpc_q        <= 32'd0;
            ebreakm_q    <= 1'b0;
            cause_q      <= 3'd0;
            en_q         <= 1'b0;
            halt_ack_q   <= 1'b0;
            resume_ack_q <= 1'b0;
            stall_q      <= 1'b0;
            pc_set_q     <= 1'b0;
            core_pc_q    <= 32'd0;
            gpr_we_q     <= 1'b0;
            gpr_waddr_q  <= 5'd0;
            gpr_wdata_q  <= 32'd0;
`ifdef HART_DBG_STEP_EN
            step_q       <= 1'b0;
            stepping_q   <= 1'b0;
            first_step_q <= 1'b0;
`endif
        end else begin
            en_q      <= rd_wr_en_i;
            dpc_q     <= dpc_d;
            ebreakm_q <= ebreakm_d;
            cause_q   <= cause_d;
`ifdef HART_DBG_STEP_EN
            step_q    <= step_d;
`endif
            gpr_we_q  <= gpr_hit;
            if (gpr_hit) begin
                gpr_waddr_q <= rd_wr_address_i[4:0];
                gpr_wdata_q <= rd_wr_data_io;
            end
            case (state_q)
                RUNNING: if (halt_req_i) begin
                    state_q <= HALT_WAIT;
                    stall_q <= 1'b1;
                end
                HALT_WAIT: if (core_idle_i) begin
                    state_q    <= HALTED;
                    halt_ack_q <= 1'b1;
                end
                HALTED: if (!halt_req_i) begin
                    state_q      <= RESUME;
                    halt_ack_q   <= 1'b0;
                    resume_ack_q <= 1'b1;
                    pc_set_q     <= 1'b1;
                    core_pc_q    <= dpc_d;
`ifdef HART_DBG_STEP_EN
                    first_step_q <= step_d;
`endif
                end
                RESUME: begin
                    resume_ack_q <= 1'b0;
                    pc_set_q     <= 1'b0;
                    stall_q      <= 1'b0;
`ifdef HART_DBG_STEP_EN
                    first_step_q <= 1'b0;
                    if (step_q) begin
                        state_q    <= STEP_RUN;
                        stepping_q <= 1'b1;
                    end else begin
                        state_q <= RUNNING;
                    end
`else
                    state_q      <= RUNNING;
`endif
                end
`ifdef HART_DBG_STEP_EN
                STEP_RUN: if (core_retire_i) begin
                    state_q <= STEP_HALT;
                    stall_q <= 1'b1;
                end
                STEP_HALT: if (core_idle_i) begin
                    state_q    <= HALTED;
                    stepping_q <= 1'b0;
                    halt_ack_q <= 1'b1;
                end
`endif
                default: state_q <= RUNNING;
            endcase
        end
    end

endmodule
